// File: rtl/i2c_slave_reg_responder.sv
// i2c_slave_reg_responder
//   Open-drain I2C slave register file. It answers SLAVE_ADDR and serves
//   pointer writes, register writes and register reads, all with pointer
//   auto-increment. SCL and SDA are oversampled on clk_200khz.
//
// Ports
//   clk_200khz   : system clock, all logic on its rising edge
//   rst          : asynchronous active-high reset
//   scl          : bus clock from the master
//   sda          : open-drain data line, only ever pulled low
//   host_wr_*    : side-band preload port into the register file
//   ptr          : current register pointer (8 bit, wraps)
//   rx_valid     : one-cycle pulse when a bus byte is written to the file
//   rx_data      : last bus-written byte, held between pulses
//   addr_match   : one-cycle pulse on an ACKed address byte
//   busy         : high from an addressed START until the next START/STOP
`timescale 1ns/1ps
module i2c_slave_reg_responder #(
  parameter logic [6:0]  SLAVE_ADDR   = 7'h68,
  parameter int unsigned ADDR_W       = 4,
  parameter logic [7:0]  INIT_PATTERN = 8'hA5
) (
  input  logic              clk_200khz,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]        host_wr_data,
  output logic [7:0]        ptr,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic              addr_match,
  output logic              busy
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
  } state_e;

  // Two-flop synchronisers plus one delayed copy for edge detection
  logic scl_meta_q, scl_s_q, scl_dly_q;
  logic sda_meta_q, sda_s_q, sda_dly_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        first_q, first_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        addr_match_q, addr_match_d;
  logic        busy_q, busy_d;
  logic [7:0]  regfile_q [Depth];
  logic [7:0]  regfile_d [Depth];

  logic        scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0]  rx_byte;
  logic [7:0]  ptr_inc;
  logic [7:0]  rd_cur, rd_next;

  assign scl_rise   = scl_s_q & ~scl_dly_q;
  assign scl_fall   = ~scl_s_q & scl_dly_q;
  assign start_cond = scl_s_q & scl_dly_q & sda_dly_q & ~sda_s_q;
  assign stop_cond  = scl_s_q & scl_dly_q & ~sda_dly_q & sda_s_q;
  assign rx_byte    = {shift_q[6:0], sda_s_q};
  assign ptr_inc    = ptr_q + 8'd1;
  assign rd_cur     = regfile_q[ptr_q[ADDR_W-1:0]];
  assign rd_next    = regfile_q[ptr_inc[ADDR_W-1:0]];

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign ptr        = ptr_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

  always_ff @(posedge clk_200khz or posedge rst) begin
    if (rst) begin
      // Synchronisers reset to the idle bus level so release sees no edge
      scl_meta_q   <= 1'b1;
      scl_s_q      <= 1'b1;
      scl_dly_q    <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_s_q      <= 1'b1;
      sda_dly_q    <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      sda_oe_q     <= 1'b0;
      ptr_q        <= 8'h00;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        regfile_q[i] <= INIT_PATTERN ^ 8'(i);
      end
    end else begin
      scl_meta_q   <= scl;
      scl_s_q      <= scl_meta_q;
      scl_dly_q    <= scl_s_q;
      sda_meta_q   <= sda;
      sda_s_q      <= sda_meta_q;
      sda_dly_q    <= sda_s_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      first_q      <= first_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
      regfile_q    <= regfile_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    ptr_d        = ptr_q;
    rw_d         = rw_q;
    first_d      = first_q;
    rx_valid_d   = 1'b0;
    rx_data_d    = rx_data_q;
    addr_match_d = 1'b0;
    busy_d       = busy_q;
    regfile_d    = regfile_q;

    // Host preload first so a same-cycle bus write to the entry overrides it
    if (host_wr_en) begin
      regfile_d[host_wr_addr] = host_wr_data;
    end

    if (start_cond) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_cond) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d      = StAddrAck;
                rw_d         = rx_byte[0];
                addr_match_d = 1'b1;
                busy_d       = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        // sda_oe_q doubles as the ACK phase: first fall pulls low, second ends the slot
        StAddrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              // ACK slot ends on the same edge that presents the first read bit
              sda_oe_d  = ~rd_cur[7];
              shift_d   = {rd_cur[6:0], 1'b0};
              bit_cnt_d = 4'd1;
              state_d   = StRdByte;
            end else begin
              sda_oe_d  = 1'b0;
              first_d   = 1'b1;
              bit_cnt_d = 4'd0;
              state_d   = StWrByte;
            end
          end
        end

        StWrByte: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = StWrAck;
              if (first_q) begin
                ptr_d = rx_byte;
              end else begin
                regfile_d[ptr_q[ADDR_W-1:0]] = rx_byte;
                ptr_d      = ptr_inc;
                rx_valid_d = 1'b1;
                rx_data_d  = rx_byte;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        StWrAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              first_d   = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StWrByte;
            end
          end
        end

        StRdByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            ptr_d = ptr_inc;
            if (!sda_s_q) begin
              shift_d   = rd_next;
              bit_cnt_d = 4'd0;
              state_d   = StRdByte;
            end else begin
              state_d = StIgnore;
            end
          end
        end

        default: begin
          // StIdle and StIgnore only leave on START/STOP
        end
      endcase
    end
  end

endmodule
